// File: rtl/matrix_keypad_scanner.sv
// Matrix keypad scanner: drives the columns, synchronises and debounces the rows, and reports one key index per press.
// Latency: key_valid rises 3+(c+1)*SETTLE+DEBOUNCE cycles after a stable press whose lowest pressed column is c.
// Backpressure: key_valid/key_code hold until key_ready; no new key is reported until every key is released.
module matrix_keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 8,
    parameter int CODE_W   = $clog2(ROWS * COLS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ROWS-1:0]   row_i,
    output logic [COLS-1:0]   col_o,
    output logic [CODE_W-1:0] key_code_o,
    output logic              key_valid_o,
    input  logic              key_ready_i
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SETTLE);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DEBOUNCE,
        ST_REPORT,
        ST_RELEASE
    } state_e;

    state_e            state_q;
    logic [ROWS-1:0]   row_meta_q;
    logic [ROWS-1:0]   row_s_q;
    logic [CW-1:0]     col_idx_q;
    logic [RW-1:0]     row_idx_q;
    logic [SW-1:0]     settle_cnt_q;
    logic [DW-1:0]     deb_cnt_q;
    logic [COLS-1:0]   col_q;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q;

    logic [RW-1:0]     lowest_row;
    logic              row_any;
    logic              row_hit;
    logic [CW-1:0]     col_idx_d;
    logic [CODE_W-1:0] key_code_d;

    // One-hot column drive for a given column index.
    function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] idx);
        col_onehot      = '0;
        col_onehot[idx] = 1'b1;
    endfunction

    assign row_any    = |row_s_q;
    assign row_hit    = row_s_q[row_idx_q];
    assign col_idx_d  = col_idx_q + CW'(1);
    assign key_code_d = CODE_W'(int'(row_idx_q) * COLS + int'(col_idx_q));

    // Priority pick of the lowest-numbered active row; scanning downward lets the lowest index win.
    always_comb begin
        lowest_row = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (row_s_q[r]) begin
                lowest_row = RW'(r);
            end
        end
    end

    // Two-flop synchroniser for the asynchronous row returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_meta_q <= '0;
            row_s_q    <= '0;
        end else begin
            row_meta_q <= row_i;
            row_s_q    <= row_meta_q;
        end
    end

    // Scan/debounce/report/release controller with registered column drive and key outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            col_idx_q    <= '0;
            row_idx_q    <= '0;
            settle_cnt_q <= '0;
            deb_cnt_q    <= '0;
            col_q        <= '1;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    col_q <= '1;
                    if (row_any) begin
                        state_q      <= ST_SCAN;
                        col_idx_q    <= '0;
                        settle_cnt_q <= '0;
                        col_q        <= col_onehot(CW'(0));
                    end
                end
                ST_SCAN: begin
                    if (settle_cnt_q == SW'(SETTLE - 1)) begin
                        if (row_any) begin
                            // Rows now reflect only the driven column, so this column holds the key.
                            row_idx_q <= lowest_row;
                            deb_cnt_q <= '0;
                            state_q   <= ST_DEBOUNCE;
                        end else if (col_idx_q == CW'(COLS - 1)) begin
                            // Whole matrix scanned with nothing found: treat the wake-up as a glitch.
                            state_q <= ST_IDLE;
                            col_q   <= '1;
                        end else begin
                            col_idx_q    <= col_idx_d;
                            settle_cnt_q <= '0;
                            col_q        <= col_onehot(col_idx_d);
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_hit) begin
                        state_q <= ST_IDLE;
                        col_q   <= '1;
                    end else if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
                        state_q     <= ST_REPORT;
                        key_code_q  <= key_code_d;
                        key_valid_q <= 1'b1;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                ST_REPORT: begin
                    // The key may already be released; the report is held regardless.
                    if (key_ready_i) begin
                        key_valid_q <= 1'b0;
                        deb_cnt_q   <= '0;
                        state_q     <= ST_RELEASE;
                        col_q       <= '1;
                    end
                end
                ST_RELEASE: begin
                    // All columns driven so any held key keeps us here: no auto-repeat.
                    col_q <= '1;
                    if (row_any) begin
                        deb_cnt_q <= '0;
                    end else if (deb_cnt_q == DW'(DEBOUNCE - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DW'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    col_q       <= '1;
                    key_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign col_o       = col_q;
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Self-checking bench: default 4x4 scanner plus a 2x8 variant, each attached to a behavioural keypad matrix.
// Expected key index and report cycle come from the key set (lowest column, then lowest row) and the timing rule.
// Random presses, ready delays and release points are mixed with directed reset, bounce and backpressure cases.
`timescale 1ns/1ps
module tb_matrix_keypad_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [3:0]       row_a;
    logic [3:0]       col_a;
    logic [3:0]       code_a;
    logic             vld_a;
    logic             rdy_a;
    logic [3:0][3:0]  press_a;

    // Instance B: ROWS=2, COLS=8, SETTLE=3, DEBOUNCE=2
    logic [1:0]       row_b;
    logic [7:0]       col_b;
    logic [3:0]       code_b;
    logic             vld_b;
    logic             rdy_b;
    logic [1:0][7:0]  press_b;

    int n_chk = 0;
    int n_err = 0;

    matrix_keypad_scanner u_dut_a (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .row_i       (row_a),
        .col_o       (col_a),
        .key_code_o  (code_a),
        .key_valid_o (vld_a),
        .key_ready_i (rdy_a)
    );

    matrix_keypad_scanner #(
        .ROWS     (2),
        .COLS     (8),
        .SETTLE   (3),
        .DEBOUNCE (2)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .row_i       (row_b),
        .col_o       (col_b),
        .key_code_o  (code_b),
        .key_valid_o (vld_b),
        .key_ready_i (rdy_b)
    );

    // Physical matrix: a row line is high when a closed key sits on a driven column.
    always_comb begin
        row_a = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_a[r][c] && col_a[c]) row_a[r] = 1'b1;
    end

    always_comb begin
        row_b = '0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 8; c++)
                if (press_b[r][c] && col_b[c]) row_b[r] = 1'b1;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_vld(input int sel);
        return (sel != 0) ? vld_b : vld_a;
    endfunction

    function automatic logic [31:0] get_code(input int sel);
        return (sel != 0) ? 32'(code_b) : 32'(code_a);
    endfunction

    function automatic logic cols_all_on(input int sel);
        return (sel != 0) ? (col_b == 8'hFF) : (col_a == 4'hF);
    endfunction

    task automatic set_rdy(input int sel, input logic v);
        if (sel != 0) rdy_b = v;
        else          rdy_a = v;
    endtask

    task automatic set_key(input int sel, input int r, input int c, input logic v);
        if (sel != 0) press_b[r][c] = v;
        else          press_a[r][c] = v;
    endtask

    task automatic clear_keys(input int sel);
        if (sel != 0) press_b = '0;
        else          press_a = '0;
    endtask

    // Reference: lowest pressed column wins, then lowest row in it; report cycle from the scan timing rule.
    task automatic model_expect(input int sel, output int code, output int cyc);
        int rows, cols, settle, deb;
        logic hit;
        rows   = (sel != 0) ? 2 : 4;
        cols   = (sel != 0) ? 8 : 4;
        settle = (sel != 0) ? 3 : 4;
        deb    = (sel != 0) ? 2 : 8;
        code   = -1;
        cyc    = -1;
        for (int c = 0; c < cols; c++) begin
            for (int r = 0; r < rows; r++) begin
                hit = (sel != 0) ? press_b[r][c] : press_a[r][c];
                if (hit && code < 0) begin
                    code = r * cols + c;
                    cyc  = 3 + (c + 1) * settle + deb;
                end
            end
        end
    endtask

    // Keys must already be set in the current cycle (cycle 0); DUT must be idle.
    task automatic run_txn(input int sel, input int rdy_delay, input logic rel_in_report,
                           input int hold_after, output int rise);
        int    exp_code, exp_cyc, viol, extra, deb;
        string pfx;
        pfx  = (sel != 0) ? "b" : "a";
        deb  = (sel != 0) ? 2 : 8;
        model_expect(sel, exp_code, exp_cyc);
        rise = -1;
        for (int k = 1; k <= 200; k++) begin
            set_rdy(sel, 1'($urandom_range(0, 1)));
            tick();
            if (get_vld(sel)) begin
                rise = k;
                break;
            end
        end
        chk_eq({pfx, "_rise_cycle"}, 32'(rise), 32'(exp_cyc));
        chk_eq({pfx, "_key_code"}, get_code(sel), 32'(exp_code));
        if (rise < 0) begin
            set_rdy(sel, 1'b0);
            clear_keys(sel);
            repeat (30) tick();
            return;
        end
        viol = 0;
        for (int w = 0; w <= rdy_delay; w++) begin
            set_rdy(sel, w == rdy_delay);
            if (rel_in_report && w == 0) clear_keys(sel);
            tick();
            if (w < rdy_delay) begin
                if (!get_vld(sel) || get_code(sel) != 32'(exp_code)) viol++;
            end
        end
        chk_eq({pfx, "_hold_viol"}, 32'(viol), 32'd0);
        chk_eq({pfx, "_vld_drop"}, 32'(get_vld(sel)), 32'd0);
        chk_eq({pfx, "_col_release"}, 32'(cols_all_on(sel)), 32'd1);
        set_rdy(sel, 1'b0);
        extra = 0;
        for (int i = 0; i < hold_after; i++) begin
            tick();
            if (get_vld(sel)) extra++;
        end
        clear_keys(sel);
        for (int i = 0; i < deb + 6; i++) begin
            tick();
            if (get_vld(sel)) extra++;
        end
        chk_eq({pfx, "_no_repeat"}, 32'(extra), 32'd0);
        chk_eq({pfx, "_col_idle"}, 32'(cols_all_on(sel)), 32'd1);
    endtask

    initial begin
        int rise, bad, seen, sel, rows, cols, nk;
        rst_n   = 1'b0;
        rdy_a   = 1'b0;
        rdy_b   = 1'b0;
        press_a = '0;
        press_b = '0;
        repeat (3) tick();
        chk_eq("rst_col_a", 32'(col_a), 32'hF);
        chk_eq("rst_vld_a", 32'(vld_a), 32'd0);
        chk_eq("rst_code_a", 32'(code_a), 32'd0);
        chk_eq("rst_col_b", 32'(col_b), 32'hFF);
        chk_eq("rst_vld_b", 32'(vld_b), 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Basic press: key (1,2)
        set_key(0, 1, 2, 1'b1);
        run_txn(0, 0, 1'b0, 5, rise);
        chk_eq("basic_cycle", 32'(rise), 32'd23);

        // Backpressure: key (0,0), ready low for 20 cycles, key released as the report rises
        set_key(0, 0, 0, 1'b1);
        run_txn(0, 20, 1'b1, 0, rise);
        chk_eq("bp_cycle", 32'(rise), 32'd15);

        // Multiple keys: (2,1) and (0,3)
        set_key(0, 2, 1, 1'b1);
        set_key(0, 0, 3, 1'b1);
        run_txn(0, 2, 1'b0, 10, rise);
        chk_eq("multi_cycle", 32'(rise), 32'd19);

        // Bounce: key (3,3) toggles every 3 cycles for 40 cycles, then held
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            set_key(0, 3, 3, ((i / 3) % 2) == 0);
            tick();
            if (vld_a) bad++;
        end
        chk_eq("bounce_quiet", 32'(bad), 32'd0);
        set_key(0, 3, 3, 1'b1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (vld_a) begin
                seen = 1;
                break;
            end
        end
        chk_eq("bounce_seen", 32'(seen), 32'd1);
        chk_eq("bounce_code", 32'(code_a), 32'd15);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        chk_eq("bounce_drop", 32'(vld_a), 32'd0);
        clear_keys(0);
        repeat (16) tick();

        // Reset mid-DEBOUNCE: key (1,2), DEBOUNCE occupies cycles 15..22
        set_key(0, 1, 2, 1'b1);
        repeat (18) tick();
        chk_eq("pre_rst_col", 32'(col_a), 32'd4);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_col", 32'(col_a), 32'hF);
        chk_eq("mid_rst_vld", 32'(vld_a), 32'd0);
        chk_eq("mid_rst_code", 32'(code_a), 32'd0);
        clear_keys(0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk_eq("post_rst_col", 32'(col_a), 32'hF);
        chk_eq("post_rst_vld", 32'(vld_a), 32'd0);

        // Reset during a pending report discards it
        set_key(0, 3, 1, 1'b1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (vld_a) begin
                seen = 1;
                break;
            end
        end
        chk_eq("rpt_seen", 32'(seen), 32'd1);
        chk_eq("rpt_code", 32'(code_a), 32'd13);
        rst_n = 1'b0;
        #1;
        chk_eq("rpt_rst_vld", 32'(vld_a), 32'd0);
        chk_eq("rpt_rst_code", 32'(code_a), 32'd0);
        clear_keys(0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vld_a) bad++;
        end
        chk_eq("rpt_discarded", 32'(bad), 32'd0);

        // Parametrised instance: key (1,7)
        set_key(1, 1, 7, 1'b1);
        run_txn(1, 1, 1'b0, 3, rise);
        chk_eq("b_cycle", 32'(rise), 32'd29);

        // Randomised presses on both instances
        for (int t = 0; t < 24; t++) begin
            sel  = ((t % 4) == 3) ? 1 : 0;
            rows = (sel != 0) ? 2 : 4;
            cols = (sel != 0) ? 8 : 4;
            nk   = $urandom_range(1, 3);
            for (int k = 0; k < nk; k++)
                set_key(sel, $urandom_range(0, rows - 1), $urandom_range(0, cols - 1), 1'b1);
            run_txn(sel, $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 12), rise);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
